// File: rtl/control_unit.sv
// control_unit: microcoded controller for the 8-bit CPU built with memory_system.
// Runs fetch (F0..F2), decode (DEC) and per-opcode execute (E0..E3) sequences
// and emits every datapath strobe.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   instruction[4:0]  - opcode from IR, sampled only in DEC
//   C, N, P, Z        - registered ALU flags (P is not used by this ISA)
//   ir_sclr, mar_sclr - synchronous clear of IR / MAR (INIT only)
//   enaf              - flag register update enable
//   selop[2:0]        - ALU op; shamt[1:0] is tied to 0
//   bank_wr_en        - register bank write
//   busB_addr[2:0]    - bus B source; busC_addr[2:0] - bus C destination
//   ir_en, mar_en, mdr_en - register load enables
//   wr_rdn            - 1 = memory write, 0 = read
//   mdr_alu_n         - MDR source: 1 = memory, 0 = ALU
//   halted            - high in HALT
//   state[3:0]        - current state (debug)
module control_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] instruction,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       mdr_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_E3   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [2:0] B_PC = 3'b000, B_DPTR = 3'b001, B_A = 3'b011;
  localparam logic [2:0] B_MDR = 3'b110, B_ACC = 3'b111;
  localparam logic [2:0] ALU_INC = 3'b001;

  localparam logic [4:0] OP_MOV_ACC_A = 5'h01, OP_MOV_A_ACC = 5'h02, OP_MOV_DPTR_ACC = 5'h03;
  localparam logic [4:0] OP_LD = 5'h04, OP_ST = 5'h05, OP_LDI = 5'h06, OP_HALT = 5'h1F;

  // Single-cycle execute: register moves and ACC,A ALU ops.
  function automatic logic is_reg(input logic [4:0] op);
    return (op >= 5'h01 && op <= 5'h03) || (op >= 5'h08 && op <= 5'h0C);
  endfunction

  // Three- or four-cycle execute: memory access, immediate load, jumps.
  function automatic logic is_long(input logic [4:0] op);
    return (op >= 5'h04 && op <= 5'h06) || (op >= 5'h10 && op <= 5'h13);
  endfunction

  state_t     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  // run_q holds everything quiet for the first edge after reset release, so
  // INIT strobes appear on that edge and F0 follows on the next.
  logic       run_q, run_d;
  logic       jump_taken;
  logic       unused_ok;

  assign unused_ok = P ^ (DATA_WIDTH == 8);
  assign state     = state_q;
  assign shamt     = 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_INIT;
      opcode_q <= 5'h00;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    run_d    = 1'b1;
    if (run_q) begin
      case (state_q)
        S_INIT: state_d = S_F0;
        S_F0:   state_d = S_F1;
        S_F1:   state_d = S_F2;
        S_F2:   state_d = S_DEC;
        S_DEC: begin
          opcode_d = instruction;
          if (instruction == OP_HALT)                            state_d = S_HALT;
          else if (is_reg(instruction) || is_long(instruction))  state_d = S_E0;
          else                                                   state_d = S_F0;
        end
        S_E0:   state_d = is_long(opcode_q) ? S_E1 : S_F0;
        S_E1:   state_d = S_E2;
        S_E2:   state_d = (opcode_q == OP_LDI) ? S_E3 : S_F0;
        S_E3:   state_d = S_F0;
        S_HALT: state_d = S_HALT;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Jump condition from opcode[1:0]: JZ, JC, JN, JMP.
  always_comb begin
    case (opcode_q[1:0])
      2'd0:    jump_taken = Z;
      2'd1:    jump_taken = C;
      2'd2:    jump_taken = N;
      default: jump_taken = 1'b1;
    endcase
  end

  always_comb begin
    ir_sclr    = 1'b0;
    mar_sclr   = 1'b0;
    enaf       = 1'b0;
    selop      = 3'b000;
    bank_wr_en = 1'b0;
    busB_addr  = B_PC;
    busC_addr  = B_PC;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    wr_rdn     = 1'b0;
    mdr_alu_n  = 1'b0;
    halted     = 1'b0;
    if (run_q) begin
      case (state_q)
        S_INIT: begin
          ir_sclr  = 1'b1;
          mar_sclr = 1'b1;
        end
        S_F0: mar_en = 1'b1;
        S_F1: begin
          mdr_en    = 1'b1;
          mdr_alu_n = 1'b1;
        end
        S_F2: begin
          ir_en      = 1'b1;
          selop      = ALU_INC;
          bank_wr_en = 1'b1;
        end
        S_E0: begin
          if (is_reg(opcode_q)) begin
            bank_wr_en = 1'b1;
            case (opcode_q)
              OP_MOV_ACC_A: begin
                busB_addr = B_A;
                busC_addr = B_ACC;
                enaf      = 1'b1;
              end
              OP_MOV_A_ACC: begin
                busB_addr = B_ACC;
                busC_addr = B_A;
              end
              OP_MOV_DPTR_ACC: begin
                busB_addr = B_ACC;
                busC_addr = B_DPTR;
              end
              default: begin
                // 01000..01100 map onto ALU ops 010..110.
                busB_addr = B_A;
                busC_addr = B_ACC;
                selop     = opcode_q[2:0] + 3'd2;
                enaf      = 1'b1;
              end
            endcase
          end else begin
            mar_en    = 1'b1;
            busB_addr = (opcode_q == OP_LD || opcode_q == OP_ST) ? B_DPTR : B_PC;
          end
        end
        S_E1: begin
          mdr_en = 1'b1;
          if (opcode_q == OP_ST) busB_addr = B_ACC;
          else                   mdr_alu_n = 1'b1;
        end
        S_E2: begin
          if (opcode_q == OP_ST) begin
            wr_rdn = 1'b1;
          end else if (opcode_q[4]) begin
            // Not taken: step PC over the address byte.
            bank_wr_en = 1'b1;
            busC_addr  = B_PC;
            if (jump_taken) busB_addr = B_MDR;
            else            selop     = ALU_INC;
          end else begin
            busB_addr  = B_MDR;
            busC_addr  = B_ACC;
            bank_wr_en = 1'b1;
            enaf       = 1'b1;
          end
        end
        S_E3: begin
          selop      = ALU_INC;
          bank_wr_en = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit. Wraps the controller in a strobe-driven datapath
// stand-in (register bank, MAR/MDR/IR, 256-byte memory, flags) and checks
// every cycle's strobes against an expected schedule built from the ISA
// description, plus architectural state against an instruction-level model.
module tb_control_unit;

  logic       clk, rst;
  logic [4:0] instruction;
  logic       C, N, P, Z;
  logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;
  logic [3:0] state;

  control_unit #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .C(C), .N(N), .P(P), .Z(Z),
    .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop), .shamt(shamt),
    .bank_wr_en(bank_wr_en), .busB_addr(busB_addr), .busC_addr(busC_addr),
    .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en), .wr_rdn(wr_rdn),
    .mdr_alu_n(mdr_alu_n), .halted(halted), .state(state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- strobe vector ----------------
  logic [20:0] dut_vec;
  assign dut_vec = {ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr, busC_addr,
                    ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted};

  localparam logic [20:0] B_IRS  = 21'h1 << 20;
  localparam logic [20:0] B_MARS = 21'h1 << 19;
  localparam logic [20:0] B_ENAF = 21'h1 << 18;
  localparam logic [20:0] B_BWE  = 21'h1 << 12;
  localparam logic [20:0] B_IRE  = 21'h1 << 5;
  localparam logic [20:0] B_MARE = 21'h1 << 4;
  localparam logic [20:0] B_MDRE = 21'h1 << 3;
  localparam logic [20:0] B_WR   = 21'h1 << 2;
  localparam logic [20:0] B_MDRA = 21'h1 << 1;
  localparam logic [20:0] B_HALT = 21'h1;
  localparam logic [20:0] V_INIT = B_IRS | B_MARS;
  localparam logic [20:0] V_RD   = B_MDRE | B_MDRA;

  function automatic logic [20:0] route(input logic [2:0] b, input logic [2:0] op, input logic [2:0] c);
    return {3'b000, op, 2'b00, 1'b0, b, c, 6'b000000};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] sched[$];
  logic [20:0] e_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath stand-in ----------------
  logic [7:0] dp_r[8];
  logic [7:0] dp_mar, dp_mdr, dp_ir;
  logic [3:0] dp_fl;                 // {C,N,Z,P}
  logic [7:0] dp_mem[256];

  // Returns {C,N,Z,P, result}.
  function automatic logic [11:0] alu(input logic [2:0] op, input logic [7:0] acc, input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, b};
      3'd1: r = {1'b0, b} + 9'd1;
      3'd2: r = {1'b0, acc} + {1'b0, b};
      3'd3: r = {1'b0, acc} - {1'b0, b};
      3'd4: r = {1'b0, acc & b};
      3'd5: r = {1'b0, acc | b};
      3'd6: r = {1'b0, acc ^ b};
      default: r = {b, 1'b0};
    endcase
    return {r[8], r[7], (r[7:0] == 8'h00), ~^r[7:0], r[7:0]};
  endfunction

  task automatic dp_apply(input logic [20:0] v);
    logic [7:0] b, mar_n, mdr_n, ir_n;
    logic [11:0] res;
    case (v[11:9])
      3'd6:       b = dp_mdr;
      3'd2, 3'd5: b = 8'h00;
      default:    b = dp_r[v[11:9]];
    endcase
    res   = alu(v[17:15], dp_r[7], b);
    mar_n = dp_mar;
    mdr_n = dp_mdr;
    ir_n  = dp_ir;
    if (v[20]) ir_n  = 8'h00;
    if (v[19]) mar_n = 8'h00;
    if (v[4])  mar_n = res[7:0];
    if (v[3])  mdr_n = v[1] ? dp_mem[dp_mar] : res[7:0];
    if (v[2])  dp_mem[dp_mar] = dp_mdr;
    if (v[5])  ir_n = dp_mdr;
    if (v[12]) dp_r[v[8:6]] = res[7:0];
    if (v[18]) dp_fl = res[11:8];
    dp_mar = mar_n;
    dp_mdr = mdr_n;
    dp_ir  = ir_n;
  endtask

  // The one compare process: strobes every cycle an expectation exists.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      check("strobes", 32'(dut_vec), 32'(e_cur));
      if (!rst) check("reset_state", 32'(state), 32'd0);
    end
    dp_apply(dut_vec);
  end

  // ---------------- instruction-level reference ----------------
  logic [7:0] r_pc, r_acc, r_a, r_dptr;
  logic [3:0] r_fl;
  logic [7:0] ref_mem[256];

  function automatic logic taken(input logic [4:0] op, input logic [3:0] fl);
    case (op[1:0])
      2'd0:    return fl[1];
      2'd1:    return fl[3];
      2'd2:    return fl[2];
      default: return 1'b1;
    endcase
  endfunction

  task automatic ref_exec();
    logic [4:0] op;
    logic [11:0] t;
    op = ref_mem[r_pc][4:0];
    r_pc = r_pc + 8'd1;
    case (op)
      5'h01: begin t = alu(3'd0, r_acc, r_a); r_acc = t[7:0]; r_fl = t[11:8]; end
      5'h02: r_a = r_acc;
      5'h03: r_dptr = r_acc;
      5'h04: begin t = alu(3'd0, r_acc, ref_mem[r_dptr]); r_acc = t[7:0]; r_fl = t[11:8]; end
      5'h05: ref_mem[r_dptr] = r_acc;
      5'h06: begin
        t = alu(3'd0, r_acc, ref_mem[r_pc]); r_acc = t[7:0]; r_fl = t[11:8]; r_pc = r_pc + 8'd1;
      end
      5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C: begin
        t = alu(3'(op - 5'd6), r_acc, r_a); r_acc = t[7:0]; r_fl = t[11:8];
      end
      5'h10, 5'h11, 5'h12, 5'h13: r_pc = taken(op, r_fl) ? ref_mem[r_pc] : r_pc + 8'd1;
      default: ;
    endcase
  endtask

  // Expected strobe sequence of one instruction, fetch included.
  task automatic build_sched(input logic [4:0] op);
    sched.delete();
    sched.push_back(route(3'd0, 3'd0, 3'd0) | B_MARE);
    sched.push_back(V_RD);
    sched.push_back(route(3'd0, 3'd1, 3'd0) | B_BWE | B_IRE);
    sched.push_back(21'd0);
    case (op)
      5'h01: sched.push_back(route(3'd3, 3'd0, 3'd7) | B_BWE | B_ENAF);
      5'h02: sched.push_back(route(3'd7, 3'd0, 3'd3) | B_BWE);
      5'h03: sched.push_back(route(3'd7, 3'd0, 3'd1) | B_BWE);
      5'h04: begin
        sched.push_back(route(3'd1, 3'd0, 3'd0) | B_MARE);
        sched.push_back(V_RD);
        sched.push_back(route(3'd6, 3'd0, 3'd7) | B_BWE | B_ENAF);
      end
      5'h05: begin
        sched.push_back(route(3'd1, 3'd0, 3'd0) | B_MARE);
        sched.push_back(route(3'd7, 3'd0, 3'd0) | B_MDRE);
        sched.push_back(B_WR);
      end
      5'h06: begin
        sched.push_back(route(3'd0, 3'd0, 3'd0) | B_MARE);
        sched.push_back(V_RD);
        sched.push_back(route(3'd6, 3'd0, 3'd7) | B_BWE | B_ENAF);
        sched.push_back(route(3'd0, 3'd1, 3'd0) | B_BWE);
      end
      5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C:
        sched.push_back(route(3'd3, 3'(op - 5'd6), 3'd7) | B_BWE | B_ENAF);
      5'h10, 5'h11, 5'h12, 5'h13: begin
        sched.push_back(route(3'd0, 3'd0, 3'd0) | B_MARE);
        sched.push_back(V_RD);
        if (taken(op, r_fl)) sched.push_back(route(3'd6, 3'd0, 3'd0) | B_BWE);
        else                 sched.push_back(route(3'd0, 3'd1, 3'd0) | B_BWE);
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Opcode is presented only in DEC; other cycles carry noise.
  task automatic tick(input logic [20:0] ev, input bit dec);
    @(posedge clk);
    #1;
    instruction = dec ? dp_ir[4:0] : 5'($urandom_range(0, 31));
    {C, N, Z, P} = dp_fl;
    exp_q.push_back(ev);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(21'd0, 1'b0);
    rst = 1'b1;
    tick(V_INIT, 1'b0);
  endtask

  task automatic arch_check();
    logic same;
    same = 1'b1;
    for (int i = 0; i < 256; i++) if (dp_mem[i] !== ref_mem[i]) same = 1'b0;
    check("pc", 32'(dp_r[0]), 32'(r_pc));
    check("acc", 32'(dp_r[7]), 32'(r_acc));
    check("a", 32'(dp_r[3]), 32'(r_a));
    check("dptr", 32'(dp_r[1]), 32'(r_dptr));
    check("flags", 32'(dp_fl), 32'(r_fl));
    check("mem", 32'(same), 32'd1);
  endtask

  task automatic run_instr();
    int i;
    build_sched(ref_mem[r_pc][4:0]);
    i = 0;
    while (sched.size() > 0) begin
      tick(sched.pop_front(), i == 3);
      i++;
    end
    @(negedge clk);
    #1;
    ref_exec();
    arch_check();
  endtask

  task automatic poke(input logic [7:0] addr, input logic [7:0] val);
    dp_mem[addr]  = val;
    ref_mem[addr] = val;
  endtask

  task automatic preload(input logic [7:0] pc, input logic [7:0] acc, input logic [7:0] a,
                         input logic [7:0] dptr, input logic [3:0] fl);
    r_pc = pc;  r_acc = acc;  r_a = a;  r_dptr = dptr;  r_fl = fl;
    dp_r[0] = pc; dp_r[7] = acc; dp_r[3] = a; dp_r[1] = dptr; dp_fl = fl;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    rst = 1'b1;
    instruction = 5'h00;
    {C, N, Z, P} = 4'h0;
    for (int i = 0; i < 8; i++) dp_r[i] = 8'h00;
    dp_mar = 8'h00; dp_mdr = 8'h00; dp_ir = 8'h00; dp_fl = 4'h0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    preload(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    #2;
    do_reset();

    // MOV ACC,A with A=0x3C
    preload(8'h00, 8'h00, 8'h3C, 8'h00, 4'h0);
    poke(8'h00, 8'h01);
    run_instr();
    check("lit_mov_acc", 32'(r_acc), 32'h3C);

    // ST [DPTR],ACC with ACC=0x5A, DPTR=0x20
    preload(8'h01, 8'h5A, 8'h11, 8'h20, 4'h0);
    poke(8'h01, 8'h05);
    run_instr();
    check("lit_st_mem", 32'(ref_mem[8'h20]), 32'h5A);

    // JZ 0x40 taken (Z=1)
    preload(8'h30, 8'h00, 8'h00, 8'h00, 4'b0010);
    poke(8'h30, 8'h10);
    poke(8'h31, 8'h40);
    run_instr();
    check("lit_jz_taken", 32'(r_pc), 32'h40);

    // JZ not taken at 0x10 with Z=0, other flags set
    preload(8'h10, 8'h00, 8'h00, 8'h00, 4'b1101);
    poke(8'h10, 8'h10);
    poke(8'h11, 8'h55);
    run_instr();
    check("lit_jz_not_taken", 32'(r_pc), 32'h12);

    // Illegal opcode 10111 behaves as NOP
    poke(8'h12, 8'h17);
    run_instr();
    check("lit_illegal_pc", 32'(r_pc), 32'h13);

    // ST aborted by reset during E1: no write, restart at INIT
    preload(8'h50, 8'h77, 8'h00, 8'h21, 4'h0);
    poke(8'h50, 8'h05);
    poke(8'h21, 8'h00);
    build_sched(5'h05);
    for (int i = 0; i < 6; i++) tick(sched.pop_front(), i == 3);
    sched.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    r_pc = r_pc + 8'd1;
    do_reset();
    check("lit_abort_mem", 32'(dp_mem[8'h21]), 32'h00);
    poke(8'h51, 8'h00);
    run_instr();

    // Randomized programs
    for (int i = 0; i < 256; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b[4:0] == 5'h1F);
      poke(8'(i), b);
    end
    preload(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    for (int n = 0; n < 200; n++) begin
      if (ref_mem[r_pc][4:0] == 5'h1F) poke(r_pc, 8'h00);
      run_instr();
    end

    // HALT: absorbing until reset
    poke(r_pc, 8'h1F);
    run_instr();
    begin
      logic [3:0] hs;
      hs = 4'h0;
      for (int i = 0; i < 20; i++) begin
        tick(B_HALT, 1'b0);
        @(negedge clk);
        #1;
        if (i == 0) hs = state;
        else check("halt_state_const", 32'(state), 32'(hs));
      end
    end
    do_reset();
    poke(r_pc, 8'h01);
    run_instr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
